// File: rtl/sar_avg_filter.sv
// Purpose: averages 2^LOG2_N SAR conversion results captured on rising edges of sample_done.
// Latency: avg_out/avg_valid update one cycle after the capture that completes a window.
// Backpressure: a result held in the output register is overwritten if not consumed, and overrun is set.
// Optional feature: define SAR_AVG_ROUND_EN for round-half-up averaging (default truncates).
module sar_avg_filter #(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_done,
  input  logic              clear,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              overrun,
  output logic [LOG2_N-1:0] sample_cnt
);

  localparam int ACC_W = DATA_W + LOG2_N;

  logic              done_prev_q, done_prev_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              vld_q, vld_d;
  logic              ovr_q, ovr_d;

  logic              capture;
  logic              complete;
  logic              xfer;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  div_src;
  logic [DATA_W-1:0] avg_res;
  logic              unused_frac;

  // Capture qualification and the average of the window including the current sample.
  always_comb begin
    capture  = sample_done & ~done_prev_q;
    complete = capture & (&cnt_q);
    xfer     = vld_q & avg_ready;
    sum      = acc_q + ACC_W'(sample_in);
`ifdef SAR_AVG_ROUND_EN
    // Worst-case sum is 2^ACC_W - N, so adding N/2 cannot carry out of ACC_W bits.
    div_src  = sum + ACC_W'(2 ** (LOG2_N - 1));
`else
    div_src  = sum;
`endif
    avg_res     = div_src[ACC_W-1:LOG2_N];
    unused_frac = ^div_src[LOG2_N-1:0];
  end

  // Next state: clear dominates; a completing capture loads the output and restarts the window.
  always_comb begin
    done_prev_d = sample_done;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    vld_d       = vld_q;
    ovr_d       = ovr_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      vld_d = 1'b0;
      ovr_d = 1'b0;
    end else begin
      if (xfer) begin
        vld_d = 1'b0;
      end
      if (capture) begin
        if (complete) begin
          acc_d = '0;
          cnt_d = '0;
          avg_d = avg_res;
          vld_d = 1'b1;
          if (vld_q && !avg_ready) begin
            ovr_d = 1'b1;
          end
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State registers; edge detector resets high so a level held through reset is not a capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_prev_q <= 1'b1;
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      vld_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      done_prev_q <= done_prev_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      vld_q       <= vld_d;
      ovr_q       <= ovr_d;
    end
  end

  assign avg_out    = avg_q;
  assign avg_valid  = vld_q;
  assign overrun    = ovr_q;
  assign sample_cnt = cnt_q;

endmodule
